fft_result_master: RTL and testbench

- Avalon-MM write master that drains FFT results to SDRAM after each transform.
- Sequence: on fft_done, reads SAMPLE_COUNT words from the FFT result memory, sign-extends each to 32 bits, and issues one single-beat Avalon write per sample at BASE_ADDR + index*ADDR_STRIDE.
- Counterpart of the host-facing Avalon slave that loads samples into the FFT: that path brings data in, this block sends results out.

---
 rtl/fft_result_master_if.sv | 32 +++
 rtl/fft_result_master.sv | 203 ++++++++++++++++++++
 tb/tb_fft_result_master.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_result_master_if.sv
// fft_result_master_if
//   Avalon-MM write-master bundle used to push FFT results to SDRAM.
//   Signals:
//     master_address      32  byte address of the current beat
//     master_write         1  write request
//     master_writedata    32  write data
//     master_byteenable    4  byte lanes (all set during a write)
//     master_waitrequest   1  slave stall, driven by the slave side
//   Modports: master (drives the request side), slave (drives waitrequest).
interface fft_result_master_if;
  logic [31:0] master_address;
  logic        master_write;
  logic [31:0] master_writedata;
  logic [3:0]  master_byteenable;
  logic        master_waitrequest;

  modport master (
    output master_address,
    output master_write,
    output master_writedata,
    output master_byteenable,
    input  master_waitrequest
  );

  modport slave (
    input  master_address,
    input  master_write,
    input  master_writedata,
    input  master_byteenable,
    output master_waitrequest
  );
endinterface

// File: rtl/fft_result_master.sv
// fft_result_master
//   Drains one FFT result frame to SDRAM after every fft_done pulse. Each
//   result word is read from the result memory, sign-extended to 32 bits and
//   written with one single-beat Avalon write at BASE_ADDR + idx*ADDR_STRIDE.
//
//   Optional build macro: STOP_MARKER_EN
//     defined   : one extra write of STOP_WORD at BASE_ADDR + SAMPLE_COUNT*ADDR_STRIDE
//                 follows the last sample (SAMPLE_COUNT+1 beats per frame)
//     undefined : exactly SAMPLE_COUNT beats per frame
//
//   Ports:
//     clk              in   system clock, rising edge
//     rst              in   synchronous active-high reset
//     fft_done         in   one-cycle pulse, result memory complete
//     rAddress         out  result memory read address
//     rReadEn          out  result memory read strobe
//     fft_result_data  in   result word, valid the cycle after rReadEn
//     avm              if   Avalon-MM write master (fft_result_master_if.master)
//     busy             out  transfer in progress
//     xfer_done        out  one-cycle pulse once every write is accepted
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for fft_done
//   FETCH | read strobe for result word idx
//   LATCH | result word valid; load address and sign-extended data
//   WRITE | Avalon write held until waitrequest drops
//   NEXT  | advance idx or finish the frame
//   MARK  | stop-marker write (STOP_MARKER_EN builds only)
//   DONE  | xfer_done pulse, back to IDLE
module fft_result_master #(
  parameter int          SAMPLE_COUNT = 256,
  parameter int          ADDR_W       = 9,
  parameter int          DATA_W       = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h0850_0000,
  parameter logic [31:0] ADDR_STRIDE  = 32'd4,
  parameter logic [31:0] STOP_WORD    = 32'h0000_0012
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fft_done,
  output logic [ADDR_W-1:0]     rAddress,
  output logic                  rReadEn,
  input  logic [DATA_W-1:0]     fft_result_data,
  fft_result_master_if.master   avm,
  output logic                  busy,
  output logic                  xfer_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_WRITE = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
`ifdef STOP_MARKER_EN
    ,
    S_MARK  = 3'd6
`endif
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SAMPLE_COUNT - 1);

`ifdef STOP_MARKER_EN
  localparam logic [31:0] MARK_ADDR = BASE_ADDR + (32'(SAMPLE_COUNT) * ADDR_STRIDE);
`else
  // The marker value only matters when the stop-marker write exists.
  logic unused_stop_word;
  assign unused_stop_word = ^STOP_WORD;
`endif

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic                rreaden_q, rreaden_d;
  logic [31:0]         maddr_q, maddr_d;
  logic                mwrite_q, mwrite_d;
  logic [31:0]         mwdata_q, mwdata_d;
  logic [3:0]          mbe_q, mbe_d;
  logic                busy_q, busy_d;
  logic                xfer_done_q, xfer_done_d;

  logic [31:0]         sample_addr;
  logic [31:0]         sample_sext;

  // Byte address wraps modulo 2^32 by construction of the 32-bit sum.
  assign sample_addr = BASE_ADDR + (32'(idx_q) * ADDR_STRIDE);
  assign sample_sext = {{(32-DATA_W){fft_result_data[DATA_W-1]}}, fft_result_data};

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      raddr_q     <= '0;
      rreaden_q   <= 1'b0;
      maddr_q     <= '0;
      mwrite_q    <= 1'b0;
      mwdata_q    <= '0;
      mbe_q       <= 4'h0;
      busy_q      <= 1'b0;
      xfer_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      raddr_q     <= raddr_d;
      rreaden_q   <= rreaden_d;
      maddr_q     <= maddr_d;
      mwrite_q    <= mwrite_d;
      mwdata_q    <= mwdata_d;
      mbe_q       <= mbe_d;
      busy_q      <= busy_d;
      xfer_done_q <= xfer_done_d;
    end
  end

  // Next-state and sample index
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (fft_done) begin
          state_d = S_FETCH;
          idx_d   = '0;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: state_d = S_WRITE;
      S_WRITE: begin
        if (!avm.master_waitrequest) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (idx_q == LATCH_GUARD(idx_q)) begin
`ifdef STOP_MARKER_EN
          state_d = S_MARK;
`else
          state_d = S_DONE;
`endif
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
`ifdef STOP_MARKER_EN
      S_MARK: begin
        if (!avm.master_waitrequest) state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Last-index compare kept in one place so NEXT reads cleanly.
  function automatic logic [ADDR_W-1:0] LATCH_GUARD(input logic [ADDR_W-1:0] unused_idx);
    logic unused_bits;
    unused_bits = ^unused_idx;
    return LAST_IDX;
  endfunction

  // Registered outputs are computed from the upcoming state so that each
  // output is valid in the same cycle the FSM sits in the matching state.
  always_comb begin
    raddr_d     = raddr_q;
    rreaden_d   = (state_d == S_FETCH);
    maddr_d     = maddr_q;
    mwdata_d    = mwdata_q;
    mwrite_d    = (state_d == S_WRITE);
    busy_d      = (state_d != S_IDLE);
    xfer_done_d = (state_d == S_DONE);

    if (state_d == S_FETCH) raddr_d = idx_d;

    // Address and data are loaded only when leaving LATCH, so they stay
    // frozen for the whole WRITE state including any waitrequest stall.
    if (state_q == S_LATCH) begin
      maddr_d  = sample_addr;
      mwdata_d = sample_sext;
    end

`ifdef STOP_MARKER_EN
    if (state_d == S_MARK) mwrite_d = 1'b1;
    if (state_q == S_NEXT && state_d == S_MARK) begin
      maddr_d  = MARK_ADDR;
      mwdata_d = STOP_WORD;
    end
`endif

    mbe_d = mwrite_d ? 4'hF : 4'h0;
  end

  assign rAddress              = raddr_q;
  assign rReadEn               = rreaden_q;
  assign avm.master_address    = maddr_q;
  assign avm.master_write      = mwrite_q;
  assign avm.master_writedata  = mwdata_q;
  assign avm.master_byteenable = mbe_q;
  assign busy                  = busy_q;
  assign xfer_done             = xfer_done_q;

endmodule

// File: tb/tb_fft_result_master.sv
module tb_fft_result_master;
  localparam int          N    = 256;
  localparam logic [31:0] BASE = 32'h0850_0000;
`ifdef STOP_MARKER_EN
  localparam int EXP_BEATS = N + 1;
  // FETCH-entry cycle to xfer_done cycle: 4*N+1 cycles inclusive, plus MARK
  localparam int EXP_LAT   = 4 * N + 1;
`else
  localparam int EXP_BEATS = N;
  // FETCH-entry cycle to xfer_done cycle: 4*N+1 cycles inclusive
  localparam int EXP_LAT   = 4 * N;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fft_done = 1'b0;
  logic [8:0]  rAddress;
  logic        rReadEn;
  logic [15:0] fft_result_data = 16'h0;
  logic        busy;
  logic        xfer_done;

  fft_result_master_if avm ();

  fft_result_master dut (
    .clk             (clk),
    .rst             (rst),
    .fft_done        (fft_done),
    .rAddress        (rAddress),
    .rReadEn         (rReadEn),
    .fft_result_data (fft_result_data),
    .avm             (avm),
    .busy            (busy),
    .xfer_done       (xfer_done)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:511];
  always @(posedge clk) if (rReadEn) fft_result_data <= mem[rAddress];

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;
  beat_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sx(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Slave responder and monitor state
  int          beat_cnt = 0, done_cnt = 0, fetch_cyc = 0, done_cyc = 0;
  int          stall_left = 0, stall_seen = 0;
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = 0, prev_data = 0;
  logic        first_pending = 1'b0;
  logic [31:0] first_addr = 0, last_addr = 0, last_data = 0, data0 = 0, data1 = 0;

  always @(negedge clk) begin
    beat_t e;
    if (avm.master_write) begin
      if (stall_left > 0 && avm.master_address == stall_addr) begin
        avm.master_waitrequest = 1'b1;
        stall_left--;
        stall_seen++;
      end else begin
        avm.master_waitrequest = 1'b0;
      end
    end else begin
      // waitrequest noise while idle must have no effect
      avm.master_waitrequest = 1'($urandom_range(0, 1));
    end

    if (prev_stall) begin
      chk("stall_addr_hold", avm.master_address, prev_addr);
      chk("stall_data_hold", avm.master_writedata, prev_data);
      chk("stall_write_hold", {31'b0, avm.master_write}, 32'd1);
    end
    prev_stall = avm.master_write && avm.master_waitrequest;
    prev_addr  = avm.master_address;
    prev_data  = avm.master_writedata;

    if (avm.master_write && !avm.master_waitrequest) begin
      beat_cnt++;
      if (first_pending) begin
        first_addr    = avm.master_address;
        first_pending = 1'b0;
      end
      last_addr = avm.master_address;
      last_data = avm.master_writedata;
      if (avm.master_address == BASE)      data0 = avm.master_writedata;
      if (avm.master_address == BASE + 4)  data1 = avm.master_writedata;
      chk("beat_byteenable", {28'b0, avm.master_byteenable}, 32'hF);
      chk("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("beat_addr", avm.master_address, e.addr);
        chk("beat_data", avm.master_writedata, e.data);
      end
    end else if (!avm.master_write) begin
      chk("idle_byteenable", {28'b0, avm.master_byteenable}, 32'h0);
    end

    if (rReadEn && rAddress == 9'd0) fetch_cyc = cyc;
    if (xfer_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic start_xfer();
    beat_t b;
    for (int k = 0; k < N; k++) begin
      b.addr = BASE + 32'(k) * 32'd4;
      b.data = sx(mem[k]);
      sb.push_back(b);
    end
`ifdef STOP_MARKER_EN
    b.addr = 32'h0850_0400;
    b.data = 32'h0000_0012;
    sb.push_back(b);
`endif
    first_pending = 1'b1;
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic pulse_ignored();
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("xfer_done_seen", {31'b0, done_cnt != d0}, 32'd1);
  endtask

  initial begin
    int b0, d0;
    logic found;
    for (int k = 0; k < 512; k++) mem[k] = 16'(k * 3);

    // Reset values
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rAddress", {23'b0, rAddress}, 32'd0);
    chk("rst_rReadEn", {31'b0, rReadEn}, 32'd0);
    chk("rst_address", avm.master_address, 32'd0);
    chk("rst_write", {31'b0, avm.master_write}, 32'd0);
    chk("rst_writedata", avm.master_writedata, 32'd0);
    chk("rst_byteenable", {28'b0, avm.master_byteenable}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_xfer_done", {31'b0, xfer_done}, 32'd0);

    // fft_done coincident with rst is lost
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_pulse_busy", {31'b0, busy}, 32'd0);
    chk("rst_pulse_beats", beat_cnt, 32'd0);

    // Full drain, no stalls, plus first-write latency
    b0 = beat_cnt; d0 = done_cnt;
    start_xfer();
    chk("fetch_rReadEn", {31'b0, rReadEn}, 32'd1);
    @(negedge clk);
    chk("latch_no_write", {31'b0, avm.master_write}, 32'd0);
    @(negedge clk);
    chk("first_write", {31'b0, avm.master_write}, 32'd1);
    chk("first_addr_early", avm.master_address, BASE);
    wait_done(d0, 3000);
    chk("run1_beats", beat_cnt - b0, EXP_BEATS);
    chk("run1_sb_empty", sb.size(), 32'd0);
    chk("run1_latency", done_cyc - fetch_cyc, EXP_LAT);
`ifdef STOP_MARKER_EN
    chk("marker_addr", last_addr, 32'h0850_0400);
    chk("marker_data", last_data, 32'h0000_0012);
`else
    chk("last_addr", last_addr, 32'h0850_03FC);
    chk("last_data", last_data, 32'h0000_02FD);
`endif
    repeat (4) @(negedge clk);
    chk("run1_done_pulses", done_cnt - d0, 32'd1);
    chk("run1_busy_low", {31'b0, busy}, 32'd0);

    // Stall on sample 5
    stall_addr = BASE + 32'h14;
    stall_left = 3;
    stall_seen = 0;
    b0 = beat_cnt; d0 = done_cnt;
    start_xfer();
    wait_done(d0, 3000);
    chk("stall_cycles", stall_seen, 32'd3);
    chk("stall_beats", beat_cnt - b0, EXP_BEATS);
    chk("stall_sb_empty", sb.size(), 32'd0);
    stall_addr = 32'hFFFF_FFFF;

    // Sign extension
    mem[0] = 16'h8001;
    mem[1] = 16'h7FFF;
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    start_xfer();
    wait_done(d0, 3000);
    chk("sext_neg", data0, 32'hFFFF_8001);
    chk("sext_pos", data1, 32'h0000_7FFF);

    // Extra fft_done pulses while busy are ignored
    repeat (2) @(negedge clk);
    b0 = beat_cnt; d0 = done_cnt;
    start_xfer();
    repeat (20) @(negedge clk);
    pulse_ignored();
    repeat (300) @(negedge clk);
    pulse_ignored();
    wait_done(d0, 3000);
    repeat (6) @(negedge clk);
    chk("ignore_beats", beat_cnt - b0, EXP_BEATS);
    chk("ignore_done_pulses", done_cnt - d0, 32'd1);
    chk("ignore_sb_empty", sb.size(), 32'd0);
    chk("ignore_busy_low", {31'b0, busy}, 32'd0);

    // Reset during sample 100, then restart from sample 0
    start_xfer();
    found = 1'b0;
    for (int n = 0; n < 3000 && !found; n++) begin
      @(negedge clk);
      if (avm.master_write && avm.master_address == BASE + 32'd400) found = 1'b1;
    end
    chk("reached_sample100", {31'b0, found}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_write", {31'b0, avm.master_write}, 32'd0);
    chk("abort_rReadEn", {31'b0, rReadEn}, 32'd0);
    chk("abort_address", avm.master_address, 32'd0);
    sb.delete();
    rst = 1'b0;
    b0 = beat_cnt;
    repeat (10) @(negedge clk);
    chk("abort_quiet", beat_cnt - b0, 32'd0);
    b0 = beat_cnt; d0 = done_cnt;
    start_xfer();
    wait_done(d0, 3000);
    chk("restart_first_addr", first_addr, BASE);
    chk("restart_beats", beat_cnt - b0, EXP_BEATS);
    chk("restart_sb_empty", sb.size(), 32'd0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
